// File: rtl/display_pkg.sv
// Shared types and helpers for the 7-segment display scan path.
package display_pkg;

    // Slot phase: dead-time blank first, then the digit is shown
    typedef enum logic {ST_BLANK, ST_SHOW} estado_t;

    localparam int unsigned NUM_DIG_DEF = 4;

    // Per-bit anode level that switches a digit off (anodes are active-low)
    localparam logic ANODO_OFF = '1;

    // Clock cycles per digit slot for a given full-frame refresh rate
    function automatic int unsigned slot_cycles(input int unsigned clk_hz,
                                                input int unsigned refresh_hz,
                                                input int unsigned num_dig);
        return clk_hz / (refresh_hz * num_dig);
    endfunction

endpackage

// File: rtl/contador_slot.sv
// Free-running per-slot cycle counter: counts 0..SLOT_CYC-1 and wraps.
// fin_blank flags the last blank cycle, fin_slot the last cycle of the slot.
module contador_slot #(
    parameter int unsigned SLOT_CYC  = 100_000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             fin_blank,
    output logic             fin_slot
);

    // Slot cycle counter, wraps at the end of each slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (fin_slot)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Phase-end decodes from the current count
    always_comb begin
        fin_blank = (cnt == CNT_W'(BLANK_CYC - 1));
        fin_slot  = (cnt == CNT_W'(SLOT_CYC - 1));
    end

endmodule

// File: rtl/planificador_display.sv
// Time-multiplex scheduler for a multi-digit 7-segment display.
// Double-buffers a packed nibble value (valid/ready), swaps it in at frame
// end, and scans one digit at a time with a blank dead-time per slot.
// Optional build macro: DISPLAY_BLANK_CEROS_EN (leading-zero suppression).
module planificador_display
    import display_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 250,
    parameter int unsigned NUM_DIG    = NUM_DIG_DEF,
    parameter int unsigned BLANK_CYC  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dato_valid,
    input  logic [4*NUM_DIG-1:0] dato,
    output logic                 dato_ready,
    output logic [NUM_DIG-1:0]   anodo,
    output logic [3:0]           digito,
    output logic                 frame_done
);

    localparam int unsigned SLOT_CYC = slot_cycles(CLK_HZ, REFRESH_HZ, NUM_DIG);
    localparam int unsigned CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_DIG - 1);

    estado_t              estado, estado_sig;
    logic [IDX_W-1:0]     idx, idx_sig;
    logic [CNT_W-1:0]     cnt;
    logic                 fin_blank, fin_slot;
    logic [4*NUM_DIG-1:0] activo, pendiente;
    logic                 pend_flag;
    logic                 aceptar;
    logic [NUM_DIG-1:0]   anodo_sig;
    logic [3:0]           digito_sig;
    logic                 mostrar;

    contador_slot #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_contador (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .fin_blank (fin_blank),
        .fin_slot  (fin_slot)
    );

    // State register: slot phase and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ST_BLANK;
            idx    <= '0;
        end else begin
            estado <= estado_sig;
            idx    <= idx_sig;
        end
    end

    // Next state: slot end has priority and advances the digit index
    always_comb begin
        estado_sig = estado;
        idx_sig    = idx;
        if (fin_slot) begin
            estado_sig = ST_BLANK;
            idx_sig    = (idx == ULTIMO) ? '0 : idx + 1'b1;
        end else if (estado == ST_BLANK && fin_blank) begin
            estado_sig = ST_SHOW;
        end
    end

    // Output decode: nibble of the current digit, anode only during SHOW
    always_comb begin
        anodo_sig  = {NUM_DIG{ANODO_OFF}};
        digito_sig = 4'h0;
        mostrar    = 1'b1;
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (idx == IDX_W'(i))
                digito_sig = activo[4*i +: 4];
        end
`ifdef DISPLAY_BLANK_CEROS_EN
        // Digit is shown if it is digit 0 or any nibble at or above it is non-zero
        mostrar = (idx == '0);
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (IDX_W'(i) >= idx && activo[4*i +: 4] != 4'h0)
                mostrar = 1'b1;
        end
`endif
        if (estado == ST_SHOW && mostrar)
            anodo_sig[idx] = ~ANODO_OFF;
    end

    // Registered outputs; frame_done is pre-decoded one cycle early so the
    // registered pulse lands exactly on the last cycle of the last slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodo      <= {NUM_DIG{ANODO_OFF}};
            digito     <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            anodo      <= anodo_sig;
            digito     <= digito_sig;
            frame_done <= (idx == ULTIMO) && (cnt == CNT_W'(SLOT_CYC - 2));
        end
    end

    assign aceptar = dato_valid && dato_ready;

    // Double buffer and handshake: pending swaps into active at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activo     <= '0;
            pendiente  <= '0;
            pend_flag  <= 1'b0;
            dato_ready <= 1'b1;
        end else if (frame_done && pend_flag) begin
            activo     <= pendiente;
            pend_flag  <= 1'b0;
            dato_ready <= 1'b1;
        end else if (aceptar) begin
            pendiente  <= dato;
            pend_flag  <= 1'b1;
            dato_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_planificador_display.sv
// Self-checking bench for planificador_display (SLOT_CYC=10, frame=40 cycles).
// Reference model predicts outputs from the cycle count since reset release.
module tb_planificador_display;

    localparam int FRAME = 40;
    localparam int SLOT  = 10;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dato_valid = 1'b0;
    logic [15:0] dato = '0;
    logic        dato_ready;
    logic [3:0]  anodo;
    logic [3:0]  digito;
    logic        frame_done;

    int passed = 0;
    int total  = 0;

    planificador_display #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (25),
        .NUM_DIG    (4),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dato_valid (dato_valid),
        .dato       (dato),
        .dato_ready (dato_ready),
        .anodo      (anodo),
        .digito     (digito),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: t = rising edges since reset release
    int          t;
    logic [15:0] m_active, m_prev, m_pend;
    logic        m_flag;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t        <= 0;
            m_active <= '0;
            m_prev   <= '0;
            m_pend   <= '0;
            m_flag   <= 1'b0;
        end else begin
            m_prev <= m_active;
            if ((t % FRAME) == FRAME - 1 && m_flag) begin
                m_active <= m_pend;
                m_flag   <= 1'b0;
            end else if (dato_valid && !m_flag) begin
                m_pend <= dato;
                m_flag <= 1'b1;
            end
            t <= t + 1;
        end
    end

    // Expected outputs: registered outputs reflect scan position t-1
    int         e_p, e_c, e_i;
    logic [3:0] e_anodo, e_digito;
    logic       e_fd, e_ready;

    always_comb begin
        e_p      = t - 1;
        e_c      = 0;
        e_i      = 0;
        e_anodo  = 4'hF;
        e_digito = 4'h0;
        e_fd     = (t % FRAME) == FRAME - 1;
        e_ready  = !m_flag;
        if (t > 0) begin
            e_c      = e_p % SLOT;
            e_i      = (e_p / SLOT) % 4;
            e_digito = m_prev[4*e_i +: 4];
            if (e_c >= BLANK) begin
                e_anodo = ~(4'b0001 << e_i);
`ifdef DISPLAY_BLANK_CEROS_EN
                if (e_i > 0 && (m_prev >> (4*e_i)) == 16'h0)
                    e_anodo = 4'hF;
`endif
            end
        end
    end

    logic [9:0] obs, expv;
    assign obs  = {anodo, digito, dato_ready, frame_done};
    assign expv = {e_anodo, e_digito, e_ready, e_fd};

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a value until accepted; ok=0 if it never was
    task automatic send(input logic [15:0] v, output bit ok);
        ok = 1'b0;
        dato = v;
        dato_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (dato_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        dato_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        tick();
        for (int n = 0; n < 2*FRAME && (t % FRAME) != pos; n++)
            tick();
    endtask

    // Wait for the pending value to be applied; ends at frame position 1
    task automatic wait_applied(input string name);
        int n;
        n = 0;
        while (!dato_ready && n < 200) begin
            tick();
            n++;
        end
        total++;
        if ((t % FRAME) != 0 || !dato_ready)
            $display("FAIL %s_ready_at_boundary: pos=%0d ready=%b, want pos=0 ready=1", name, t % FRAME, dato_ready);
        else
            passed++;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (obs !== {4'hF, 4'h0, 1'b1, 1'b0})
            $display("FAIL reset_values: got %h want %h", obs, {4'hF, 4'h0, 1'b1, 1'b0});
        else
            passed++;
        rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            tick();
            total++;
            if (obs !== expv)
                $display("FAIL reset_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
        end
    endtask

    task automatic test_load();
        bit          ok;
        logic [15:0] val;
        logic [3:0]  an;
        int          i;
        val = 16'h1234;
        send(val, ok);
        total++;
        if (!ok) $display("FAIL load_accept: got 0 want 1"); else passed++;
        wait_applied("load");
        for (int k = 0; k < FRAME; k++) begin
            total++;
            if (obs !== expv)
                $display("FAIL load_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
            if ((t % SLOT) == 5) begin
                i  = ((t - 1) / SLOT) % 4;
                an = ~(4'b0001 << i);
                total++;
                if ({anodo, digito} !== {an, val[4*i +: 4]})
                    $display("FAIL load_digit%0d: got %h want %h", i, {anodo, digito}, {an, val[4*i +: 4]});
                else
                    passed++;
            end
            tick();
        end
    endtask

    task automatic test_frame_done();
        int pulses, last, gap_bad;
        pulses = 0; last = -1; gap_bad = 0;
        for (int k = 0; k < 3*FRAME; k++) begin
            tick();
            total++;
            if (frame_done !== e_fd)
                $display("FAIL frame_done t=%0d: got %b want %b", t, frame_done, e_fd);
            else
                passed++;
            if (frame_done === 1'b1) begin
                if (last >= 0 && k - last != FRAME) gap_bad++;
                last = k;
                pulses++;
            end
        end
        total++;
        if (pulses != 3 || gap_bad != 0)
            $display("FAIL frame_done_count: got %0d pulses (%0d bad gaps) want 3 (0)", pulses, gap_bad);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        logic [3:0] want;
        send(16'hAAAA, ok);
        total++;
        if (!ok) $display("FAIL b2b_accept_a: got 0 want 1"); else passed++;
        dato = 16'h5555;
        dato_valid = 1'b1;
        n = 0;
        while (!dato_ready && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n > FRAME || (t % FRAME) != 0)
            $display("FAIL b2b_ready_wait: waited %0d at pos %0d, want <=%0d at pos 0", n, t % FRAME, FRAME);
        else
            passed++;
        tick();
        dato_valid = 1'b0;
        total++;
        if (dato_ready !== 1'b0)
            $display("FAIL b2b_accept_b: ready=%b want 0", dato_ready);
        else
            passed++;
        for (int k = 0; k < 2*FRAME; k++) begin
            total++;
            if (obs !== expv)
                $display("FAIL b2b_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
            if ((t % SLOT) == 5) begin
                want = (k < FRAME) ? 4'hA : 4'h5;
                total++;
                if (digito !== want)
                    $display("FAIL b2b_digit k=%0d: got %h want %h", k, digito, want);
                else
                    passed++;
            end
            tick();
        end
    endtask

    task automatic test_boundary_race();
        logic [15:0] val;
        logic [3:0]  want;
        val = 16'hBEEF;
        wait_pos(FRAME - 1);
        total++;
        if ({frame_done, dato_ready} !== 2'b11)
            $display("FAIL race_boundary: fd/ready=%b want 11", {frame_done, dato_ready});
        else
            passed++;
        dato = val;
        dato_valid = 1'b1;
        tick();
        dato_valid = 1'b0;
        total++;
        if (dato_ready !== 1'b0)
            $display("FAIL race_accept: ready=%b want 0", dato_ready);
        else
            passed++;
        tick();
        for (int k = 0; k < 2*FRAME; k++) begin
            total++;
            if (obs !== expv)
                $display("FAIL race_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
            if ((t % SLOT) == 5) begin
                want = (k < FRAME) ? 4'h5 : val[4*(((t - 1) / SLOT) % 4) +: 4];
                total++;
                if (digito !== want)
                    $display("FAIL race_digit k=%0d: got %h want %h", k, digito, want);
                else
                    passed++;
            end
            tick();
        end
    endtask

    task automatic test_blank_ceros();
        bit          ok;
        logic [15:0] vals [2];
        logic [15:0] an_tab [2];
        int          i;
        vals[0] = 16'h0070;
        vals[1] = 16'h0000;
`ifdef DISPLAY_BLANK_CEROS_EN
        an_tab[0] = {4'hF, 4'hF, 4'b1101, 4'b1110};
        an_tab[1] = {4'hF, 4'hF, 4'hF, 4'b1110};
`else
        an_tab[0] = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        an_tab[1] = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
`endif
        for (int v = 0; v < 2; v++) begin
            send(vals[v], ok);
            total++;
            if (!ok) $display("FAIL ceros_accept%0d: got 0 want 1", v); else passed++;
            wait_applied("ceros");
            for (int k = 0; k < FRAME; k++) begin
                if ((t % SLOT) == 5) begin
                    i = ((t - 1) / SLOT) % 4;
                    total++;
                    if ({anodo, digito} !== {an_tab[v][4*i +: 4], vals[v][4*i +: 4]})
                        $display("FAIL ceros_%h_digit%0d: got %h want %h", vals[v], i, {anodo, digito},
                                 {an_tab[v][4*i +: 4], vals[v][4*i +: 4]});
                    else
                        passed++;
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        bit took;
        took = 1'b0;
        for (int k = 0; k < 400; k++) begin
            total++;
            if (obs !== expv)
                $display("FAIL random_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
            if (!dato_valid || took) begin
                dato_valid = ($urandom_range(0, 3) == 0);
                dato = 16'($urandom);
            end
            took = dato_valid && dato_ready;
            tick();
        end
        dato_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        wait_pos(25);
        total++;
        if (obs !== expv)
            $display("FAIL mid_before t=%0d: got %h want %h", t, obs, expv);
        else
            passed++;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== {4'hF, 4'h0, 1'b1, 1'b0})
            $display("FAIL mid_reset_values: got %h want %h", obs, {4'hF, 4'h0, 1'b1, 1'b0});
        else
            passed++;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (obs !== expv)
                $display("FAIL mid_scan t=%0d: got %h want %h", t, obs, expv);
            else
                passed++;
            if (t == 1 || t == 5) begin
                total++;
                if (anodo !== ((t == 1) ? 4'hF : 4'b1110))
                    $display("FAIL mid_restart t=%0d: anodo %b want %b", t, anodo, (t == 1) ? 4'hF : 4'b1110);
                else
                    passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_frame_done();
        test_back_to_back();
        test_boundary_race();
        test_blank_ceros();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
